// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= v; sizes the step counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Request/result bundle between a client and the shift-add multiplier.
interface seq_shift_add_mult_if #(
  parameter int unsigned N = 16
);
  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/carry_la_adder.sv
// N-bit adder with every carry expanded directly from generate/propagate terms.
module carry_la_adder #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   carry;
  logic         run_c;
  logic         run_p;

  assign g = a & b;
  assign p = a ^ b;

  // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c_in
  always_comb begin
    carry    = '0;
    run_c    = 1'b0;
    run_p    = 1'b0;
    carry[0] = c_in;
    for (int i = 0; i < int'(N); i++) begin
      run_c = g[i];
      run_p = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        run_c = run_c | (run_p & g[j]);
        run_p = run_p & p[j];
      end
      carry[i+1] = run_c | (run_p & c_in);
    end
  end

  assign sum   = p ^ carry[N-1:0];
  assign c_out = carry[N];
endmodule

// File: rtl/seq_shift_add_mult.sv
// Unsigned radix-2 shift-add multiplier: one adder step per cycle, result N+1 cycles after start.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_shift_add_mult_if.slave   bus
);
  localparam int unsigned CW = clog2(N);
  localparam int unsigned PW = 2 * N;

  state_t          state;
  logic [N-1:0]    mcand;
  logic [N-1:0]    acc_hi;
  logic [N-1:0]    acc_lo;
  logic [CW-1:0]   count;
  logic            busy;
  logic            done;
  logic [PW-1:0]   product;

  logic [N-1:0]    addend;
  logic [N-1:0]    sum;
  logic            c_out;
  logic [PW-1:0]   shifted;

  assign addend = acc_lo[0] ? mcand : '0;

  carry_la_adder #(.N(N)) u_step_adder (
    .a     (acc_hi),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // Adder carry becomes the new MSB; the consumed multiplier bit falls off the bottom.
  assign shifted = {c_out, sum, acc_lo[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= CALC;
            busy   <= 1'b1;
            mcand  <= bus.a;
            acc_hi <= '0;
            acc_lo <= bus.b;
            count  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          {acc_hi, acc_lo} <= shifted;
          if (count == CW'(N - 1)) begin
            // Final step: publish the product as DONE is entered.
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= shifted;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: vector table, random products and control corner cases.
module tb_seq_shift_add_mult;
  localparam int unsigned N = 16;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] expected;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  seq_shift_add_mult_if #(.N(N)) bus ();

  seq_shift_add_mult #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands for one cycle; returns at the falling edge after acceptance.
  task automatic pulse_start(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = N'($urandom);
    bus.b     = N'($urandom);
  endtask

  // Watch N busy cycles, then check the done cycle. poke >= 0 fires an extra start mid-run.
  task automatic wait_result(input string name, input logic [2*N-1:0] exp, input int poke,
                             input bit chain, input logic [N-1:0] na, input logic [N-1:0] nb);
    int bad;
    bad = 0;
    for (int k = 0; k < int'(N); k++) begin
      if (!(bus.busy === 1'b1 && bus.done === 1'b0)) bad++;
      if (k == poke) begin
        bus.start = 1'b1;
        bus.a     = 16'd2;
        bus.b     = 16'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check({name, "_busy_window"}, 64'(bad), 64'd0);
    check({name, "_done"}, 64'({bus.done, bus.busy}), 64'b10);
    check({name, "_product"}, 64'(bus.product), 64'(exp));
    if (chain) begin
      bus.start = 1'b1;
      bus.a     = na;
      bus.b     = nb;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = N'($urandom);
      bus.b     = N'($urandom);
      check({name, "_b2b_no_idle"}, 64'({bus.busy, bus.done}), 64'b10);
      check({name, "_hold_in_calc"}, 64'(bus.product), 64'(exp));
    end else begin
      @(negedge clk);
      check({name, "_back_idle"}, 64'({bus.busy, bus.done}), 64'b00);
      check({name, "_hold_idle"}, 64'(bus.product), 64'(exp));
    end
  endtask

  initial begin
    vec_t           vecs[5];
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    int             bad;

    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0] = '{a: 16'd3,     b: 16'd5,     expected: 32'h0000_000F};
    vecs[1] = '{a: 16'hFFFF,  b: 16'hFFFF,  expected: 32'hFFFE_0001};
    vecs[2] = '{a: 16'h1234,  b: 16'h0000,  expected: 32'h0000_0000};
    vecs[3] = '{a: 16'h0000,  b: 16'hABCD,  expected: 32'h0000_0000};
    vecs[4] = '{a: 16'h8000,  b: 16'h0002,  expected: 32'h0001_0000};

    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({bus.busy, bus.done, bus.product}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      pulse_start(vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), vecs[i].expected, -1, 1'b0, '0, '0);
    end

    // Random operands against plain integer multiplication.
    for (int i = 0; i < 12; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i == 0) ra = '1;
      pulse_start(ra, rb);
      wait_result($sformatf("rand%0d", i), 32'(ra) * 32'(rb), -1, 1'b0, '0, '0);
    end

    // Start while busy must be ignored.
    pulse_start(16'd7, 16'd9);
    wait_result("ignore_start", 32'd63, 5, 1'b0, '0, '0);

    // Reset mid-calculation: immediate clear, no done afterwards.
    pulse_start(16'd100, 16'd200);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", 64'({bus.busy, bus.done, bus.product}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (2 * N) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("abort_no_done", 64'(bad), 64'd0);
    pulse_start(16'd100, 16'd200);
    wait_result("after_abort", 32'd20000, -1, 1'b0, '0, '0);

    // start coincident with rst loses.
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'd5;
    bus.b     = 16'd5;
    @(negedge clk);
    check("rst_beats_start", 64'({bus.busy, bus.product}), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_beats_start_idle", 64'(bus.busy), 64'd0);

    // Back-to-back: second start taken on the done cycle.
    pulse_start(16'd11, 16'd13);
    wait_result("b2b_first", 32'd143, -1, 1'b1, 16'd6, 16'd7);
    wait_result("b2b_second", 32'd42, -1, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Unsigned radix-2 sequential shift-add multiplier. Consumes one N-bit addition result per cycle from a carry-lookahead adder.
- Used where a full array multiplier is too large; trades latency (N+1 cycles) for area.
- Sits downstream of the adder: registers each adder sum/carry-out and shifts it into the partial-product register.

Parameters:
- N, 16, operand width in bits (N >= 2); product width is 2N.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to multiply a*b; sampled on rising clk edge
- a  input  N  multiplicand, unsigned; captured when start is accepted
- b  input  N  multiplier, unsigned; captured when start is accepted
- busy  output  1  high while a multiplication is in progress (CALC state)
- done  output  1  one-cycle pulse; product valid
- product  output  2N  result a*b; held until the next accepted start

Behaviour:
- Interface: one clock domain (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, internal registers (mcand, acc_hi, acc_lo, count) = 0.
- Start acceptance:
  - start is accepted on a rising edge when busy=0, i.e. in state IDLE or DONE.
  - start while busy=1 is ignored; captured operands are unaffected.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 -> CALC; load mcand<=a, acc_hi<=0, acc_lo<=b, count<=0.
  - CALC: busy=1. Each cycle performs one shift-add step and increments count. When count reaches N-1, the step completes and the state moves to DONE.
  - DONE: done=1 for exactly one cycle; product<={acc_hi,acc_lo}.
    - start=1 -> CALC with a fresh load (back-to-back operation).
    - Otherwise -> IDLE.
- Shift-add step, per CALC cycle:
  - Addend = acc_lo[0] ? mcand : 0.
  - {c, s} = acc_hi + addend, computed by the N-bit adder instance with c_in=0.
  - {acc_hi, acc_lo} <= {c, s, acc_lo[N-1:1]}, i.e. a 2N+1-bit right shift that drops the consumed multiplier bit.
- Latency:
  - start accepted at edge t0; CALC occupies the N cycles after t0.
  - done=1 and product valid during the cycle after edge t0+N, i.e. N+1 cycles after start.
  - Throughput: one result per N+1 cycles with back-to-back starts.
- product register is written only on entry to DONE; it otherwise holds its value, including during a following CALC.
- Counter width is $clog2(N). count wraps only through reload; it never counts past N-1.
- Boundary conditions:
  - a=0 or b=0 -> product=0 after the full N+1 latency. There is no early termination.
  - Maximum operands give no overflow: (2^N-1)^2 < 2^(2N). Carry-out c is always captured into acc_hi[N-1].
  - rst asserted mid-CALC: immediate abort to IDLE with all reset values; no done pulse.
  - start and rst together: rst wins.
  - a and b may change freely after acceptance.

Decomposition:
- Shared package (mult_pkg):
  - FSM state encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Counter-width function clog2 helper.
- Sub-module: carry_la_adder #(N), instantiated once as the step adder; its c_out feeds the shift-in bit.
- Control FSM and datapath stay in one module; no further split.

Test Plan:
- N=16, a=3, b=5, start pulsed 1 cycle -> busy=1 for 16 cycles; done=1 on cycle 17 after start; product=32'h0000000F; then IDLE.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001 on the done cycle; busy drops in the same cycle done rises.
- a=16'h1234, b=0, then a=0, b=16'hABCD -> product=0 for both, each with full 17-cycle latency.
- Start a=7, b=9; at cycle 5 pulse start with a=2, b=2 -> second start ignored; product=63.
- Start a=100, b=200; assert rst at cycle 8 -> busy=0, done=0, product=0 immediately, with no done pulse afterwards. Then start a=100, b=200 -> product=20000.
- Back-to-back: start a=11, b=13; hold start=1 with a=6, b=7 on the done cycle -> done=1 with product=143. Second run begins without an IDLE cycle; next done 17 cycles later with product=42.
